// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ valid/ready requesters.
// One issue register feeds the ALU; results land in per-requester response registers.
module alu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [4*NUM_REQ-1:0]            req_func,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_op1,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_op2,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH*NUM_REQ-1:0]   rsp_result,
    output logic [NUM_REQ-1:0]              rsp_err,
    output logic [3:0]                      alu_func,
    output logic [DATA_WIDTH-1:0]           alu_op1,
    output logic [DATA_WIDTH-1:0]           alu_op2,
    input  logic [DATA_WIDTH-1:0]           alu_result
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = IDW + 1;

    function automatic logic func_legal(input logic [3:0] f);
        return (f >= 4'd1) && (f <= 4'd10);
    endfunction

    function automatic logic func_illegal(input logic [3:0] f);
        return (f >= 4'd11);
    endfunction

    logic                          iss_valid_r;
    logic [IDW-1:0]                iss_id_r;
    logic [3:0]                    iss_func_r;
    logic [DATA_WIDTH-1:0]         iss_op1_r;
    logic [DATA_WIDTH-1:0]         iss_op2_r;
    logic [IDW-1:0]                last_grant_r;
    logic [NUM_REQ-1:0]            rsp_valid_r;
    logic [DATA_WIDTH*NUM_REQ-1:0] rsp_result_r;
    logic [NUM_REQ-1:0]            rsp_err_r;
    logic [3:0]                    alu_func_r;
    logic [DATA_WIDTH-1:0]         alu_op1_r;
    logic [DATA_WIDTH-1:0]         alu_op2_r;

    logic [NUM_REQ-1:0]            pending_s;
    logic [NUM_REQ-1:0]            eligible_s;
    logic [NUM_REQ-1:0]            grant_s;
    logic                          grant_any_s;
    logic [IDW-1:0]                grant_id_s;
    logic [CW-1:0]                 scan_s;
    logic [3:0]                    sel_func_s;

    // Slot is busy while its op is in the issue register or its response is unconsumed.
    always_comb begin
        pending_s  = '0;
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending_s[i]  = rsp_valid_r[i] | (iss_valid_r & (iss_id_r == IDW'(i)));
            eligible_s[i] = req_valid[i] & ~pending_s[i];
        end
    end

    // Round-robin scan starting one past the last winner, wrapping at NUM_REQ.
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        grant_s     = '0;
        scan_s      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_s = {1'b0, last_grant_r} + CW'(k);
            if (scan_s >= CW'(NUM_REQ)) begin
                scan_s = scan_s - CW'(NUM_REQ);
            end else begin
                scan_s = scan_s;
            end
            if (!grant_any_s && eligible_s[scan_s[IDW-1:0]]) begin
                grant_any_s = 1'b1;
                grant_id_s  = scan_s[IDW-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        if (grant_any_s && rst_n) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        sel_func_s = req_func[grant_id_s*4 +: 4];
    end

    // Issue register and the registered ALU drive (zeroed for code 0 and illegal codes).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_valid_r  <= 1'b0;
            iss_id_r     <= '0;
            iss_func_r   <= 4'd0;
            iss_op1_r    <= '0;
            iss_op2_r    <= '0;
            last_grant_r <= IDW'(NUM_REQ - 1);
            alu_func_r   <= 4'd0;
            alu_op1_r    <= '0;
            alu_op2_r    <= '0;
        end else if (grant_any_s) begin
            iss_valid_r  <= 1'b1;
            iss_id_r     <= grant_id_s;
            iss_func_r   <= sel_func_s;
            iss_op1_r    <= req_op1[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
            iss_op2_r    <= req_op2[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
            last_grant_r <= grant_id_s;
            if (func_legal(sel_func_s)) begin
                alu_func_r <= sel_func_s;
                alu_op1_r  <= req_op1[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
                alu_op2_r  <= req_op2[grant_id_s*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                alu_func_r <= 4'd0;
                alu_op1_r  <= '0;
                alu_op2_r  <= '0;
            end
        end else begin
            iss_valid_r <= 1'b0;
            alu_func_r  <= 4'd0;
            alu_op1_r   <= '0;
            alu_op2_r   <= '0;
        end
    end

    // Completion into the issuing slot; consume clears valid but leaves data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r  <= '0;
            rsp_result_r <= '0;
            rsp_err_r    <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (iss_valid_r && (iss_id_r == IDW'(i))) begin
                    rsp_valid_r[i] <= 1'b1;
                    rsp_result_r[i*DATA_WIDTH +: DATA_WIDTH] <=
                        func_legal(iss_func_r) ? alu_result : '0;
                    rsp_err_r[i]   <= func_illegal(iss_func_r);
                end else if (rsp_valid_r[i] && rsp_ready[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = grant_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;
    assign alu_func   = alu_func_r;
    assign alu_op1    = alu_op1_r;
    assign alu_op2    = alu_op2_r;

    logic unused_s;
    assign unused_s = ^{iss_op1_r, iss_op2_r};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table through a bench-side ALU model,
// plus hand-written contention, backpressure and reset sequences.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_func;
    logic [DW*N-1:0] req_op1;
    logic [DW*N-1:0] req_op2;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW*N-1:0] rsp_result;
    logic [N-1:0]    rsp_err;
    logic [3:0]      alu_func;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [DW-1:0]   alu_result;

    int n_total;
    int n_pass;

    alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_func(alu_func), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shared ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_func)
            4'd1:    alu_result = alu_op1 + alu_op2;
            4'd2:    alu_result = alu_op1 - alu_op2;
            4'd3:    alu_result = alu_op1 << alu_op2[4:0];
            4'd4:    alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            4'd5:    alu_result = alu_op1 ^ alu_op2;
            4'd6:    alu_result = alu_op1 | alu_op2;
            4'd7:    alu_result = alu_op1 & alu_op2;
            4'd8:    alu_result = alu_op1 >> alu_op2[4:0];
            4'd9:    alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            4'd10:   alu_result = {31'd0, alu_op1 < alu_op2};
            default: alu_result = 32'd0;
        endcase
    end

    typedef struct {
        int          id;
        logic [3:0]  func;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic        err;
        logic [3:0]  afunc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input int id, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        req_func[id*4 +: 4]   = f;
        req_op1[id*DW +: DW]  = a;
        req_op2[id*DW +: DW]  = b;
        req_valid[id]         = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.id, v.func, v.op1, v.op2);
        #2;
        check("vec_req_ready", {31'd0, req_ready[v.id]}, 32'd1);
        @(negedge clk);
        req_valid = '0;
        #2;
        check("vec_alu_func", {28'd0, alu_func}, {28'd0, v.afunc});
        check("vec_alu_op1", alu_op1, (v.afunc != 4'd0) ? v.op1 : 32'd0);
        check("vec_rsp_early", {31'd0, rsp_valid[v.id]}, 32'd0);
        @(negedge clk);
        #2;
        check("vec_rsp_valid", {31'd0, rsp_valid[v.id]}, 32'd1);
        check("vec_rsp_result", rsp_result[v.id*DW +: DW], v.res);
        check("vec_rsp_err", {31'd0, rsp_err[v.id]}, {31'd0, v.err});
        @(negedge clk);
        #2;
        check("vec_rsp_consumed", {31'd0, rsp_valid[v.id]}, 32'd0);
    endtask

    initial begin
        logic [5:0] exp_rdy0;
        logic [5:0] exp_rdy1;
        logic [5:0] exp_rv0;
        logic [5:0] exp_rv1;

        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_func  = '0;
        req_op1   = '0;
        req_op2   = '0;

        vecs[0]  = '{0, 4'd1,  32'd5,          32'd7,          32'd12,         1'b0, 4'd1};
        vecs[1]  = '{0, 4'd2,  32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 4'd2};
        vecs[2]  = '{1, 4'd3,  32'd1,          32'd4,          32'h10,         1'b0, 4'd3};
        vecs[3]  = '{0, 4'd4,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b0, 4'd4};
        vecs[4]  = '{1, 4'd5,  32'h0000F0F0,   32'h0000FF00,   32'h00000FF0,   1'b0, 4'd5};
        vecs[5]  = '{0, 4'd6,  32'h00000F00,   32'h000000F0,   32'h00000FF0,   1'b0, 4'd6};
        vecs[6]  = '{1, 4'd7,  32'hFF00FF00,   32'h0FF00FF0,   32'h0F000F00,   1'b0, 4'd7};
        vecs[7]  = '{0, 4'd9,  32'h80000000,   32'd4,          32'hF8000000,   1'b0, 4'd9};
        vecs[8]  = '{1, 4'd8,  32'h80000000,   32'd4,          32'h08000000,   1'b0, 4'd8};
        vecs[9]  = '{0, 4'd10, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 4'd10};
        vecs[10] = '{1, 4'd10, 32'd1,          32'hFFFFFFFF,   32'd1,          1'b0, 4'd10};
        vecs[11] = '{1, 4'd12, 32'd9,          32'd9,          32'd0,          1'b1, 4'd0};
        vecs[12] = '{0, 4'd0,  32'd7,          32'd7,          32'd0,          1'b0, 4'd0};
        vecs[13] = '{1, 4'd15, 32'd3,          32'd4,          32'd0,          1'b1, 4'd0};

        // Reset state, with requests already asserted
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        #2;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", rsp_result[31:0] | rsp_result[63:32], 32'd0);
        check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        check("rst_alu_func", {28'd0, alu_func}, 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 2'b11;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Contention: both valid, rsp_ready high; grants alternate with a 3-cycle period each
        do_reset();
        rsp_ready = 2'b11;
        exp_rdy0  = 6'b001001;
        exp_rdy1  = 6'b010010;
        exp_rv0   = 6'b100100;
        exp_rv1   = 6'b001000;
        drive(0, 4'd2, 32'd3, 32'd5);
        drive(1, 4'd3, 32'd1, 32'd4);
        for (int c = 0; c < 6; c++) begin
            #2;
            check("cont_ready0", {31'd0, req_ready[0]}, {31'd0, exp_rdy0[c]});
            check("cont_ready1", {31'd0, req_ready[1]}, {31'd0, exp_rdy1[c]});
            check("cont_rsp_valid0", {31'd0, rsp_valid[0]}, {31'd0, exp_rv0[c]});
            check("cont_rsp_valid1", {31'd0, rsp_valid[1]}, {31'd0, exp_rv1[c]});
            if (rsp_valid[0]) check("cont_result0", rsp_result[31:0], 32'hFFFFFFFE);
            if (rsp_valid[1]) check("cont_result1", rsp_result[63:32], 32'h00000010);
            @(negedge clk);
        end
        req_valid = '0;

        // Backpressure on requester 0 while requester 1 keeps being served
        do_reset();
        rsp_ready = 2'b10;
        @(negedge clk);
        drive(0, 4'd4, 32'hFFFFFFFF, 32'd1);
        #2;
        check("bp_ready0_first", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        drive(0, 4'd1, 32'd1, 32'd1);
        #2;
        check("bp_ready0_busy", {31'd0, req_ready[0]}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 4'd1, 32'd2, 32'd3);
            if (c == 1) req_valid[1] = 1'b0;
            #2;
            check("bp_rsp_valid0", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_rsp_result0", rsp_result[31:0], 32'd1);
            check("bp_ready0_held", {31'd0, req_ready[0]}, 32'd0);
            if (c == 0) check("bp_ready1", {31'd0, req_ready[1]}, 32'd1);
            if (c == 2) begin
                check("bp_rsp_valid1", {31'd0, rsp_valid[1]}, 32'd1);
                check("bp_rsp_result1", rsp_result[63:32], 32'd5);
            end
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #2;
        check("bp_ready0_release", {31'd0, req_ready[0]}, 32'd0);
        @(negedge clk);
        #2;
        check("bp_rsp_valid0_clr", {31'd0, rsp_valid[0]}, 32'd0);
        check("bp_ready0_again", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2;
        check("bp_second_result", rsp_result[31:0], 32'd2);

        // Reset at the edge after accept drops the in-flight op
        @(negedge clk);
        @(negedge clk);
        drive(0, 4'd1, 32'd5, 32'd7);
        #2;
        check("rm_ready0", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        check("rm_no_rsp", {30'd0, rsp_valid}, 32'd0);
        check("rm_ready_gated", {30'd0, req_ready}, 32'd0);
        check("rm_alu_func", {28'd0, alu_func}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("rm_first_grant", {30'd0, req_ready}, 32'd1);
        check("rm_still_no_rsp", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ requesters, e.g. the execute stage and the address-generation / branch-compare path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requests are selected round-robin and latched into a single issue register that drives the shared ALU.
- Results are captured into a per-requester response register, with at most one outstanding operation per requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 32, operand/result width; the ALU is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted this cycle.
- req_func  in  4*NUM_REQ  ALU function code; slice i is [4i+3:4i].
- req_op1  in  DATA_WIDTH*NUM_REQ  operand 1 per requester.
- req_op2  in  DATA_WIDTH*NUM_REQ  operand 2 per requester.
- rsp_valid  out  NUM_REQ  response valid per requester.
- rsp_ready  in  NUM_REQ  response consumed per requester.
- rsp_result  out  DATA_WIDTH*NUM_REQ  result per requester.
- rsp_err  out  NUM_REQ  illegal function code flag per requester.
- alu_func  out  4  to shared ALU.
- alu_op1  out  DATA_WIDTH  to shared ALU.
- alu_op2  out  DATA_WIDTH  to shared ALU.
- alu_result  in  DATA_WIDTH  from shared ALU (combinational).

Behaviour:
- Function codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10. Codes 11..15 are illegal.
- State:
  - Issue register: iss_valid, iss_id, iss_func, iss_op1, iss_op2.
  - Per-requester response registers: rsp_valid, rsp_result, rsp_err.
  - Round-robin pointer last_grant.
- pending[i] = rsp_valid[i] OR (iss_valid AND iss_id==i).
- eligible[i] = req_valid[i] AND NOT pending[i].
- Grant: the first eligible index scanning from last_grant+1 upward with wrap. At most one grant per cycle.
  - req_ready[i] = grant_i; it may depend combinationally on req_valid.
  - Requesters must not make req_valid depend on req_ready.
- Accept, at the edge where req_valid[i] & req_ready[i]:
  - iss_valid<=1, iss_id<=i, func/ops latched, last_grant<=i.
  - If nothing is granted: iss_valid<=0 and last_grant holds.
- ALU drive:
  - While iss_valid and iss_func is 1..10: alu_func/op1/op2 = issue register.
  - Otherwise all three = 0.
- Completion, at the edge after accept (iss_valid=1):
  - rsp_valid[iss_id]<=1.
  - rsp_result = alu_result for func 1..10; 0 for func 0 and illegal codes.
  - rsp_err = 1 only for codes 11..15.
  - The issue register never stalls; the destination slot is guaranteed empty by the pending rule.
- Latency: request accepted at edge T, rsp_valid high after edge T+1 (2 cycles valid-to-response minimum).
- Throughput:
  - One accept per cycle across requesters.
  - Per requester, one per 3 cycles when rsp_ready is held high. A slot freed by a rsp handshake at edge T is eligible only for grants evaluated after T (no same-cycle bypass).
- Response hold: rsp_valid/rsp_result/rsp_err stay stable until the rsp_valid & rsp_ready edge, then rsp_valid<=0.
- Reset values (rst_n=0 at edge):
  - iss_valid=0; all rsp_valid=0, rsp_result=0, rsp_err=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0 while rst_n=0; alu_* = 0.
  - In-flight operations are dropped with no response.
- Simultaneous events:
  - All requesters valid: round-robin fairness, each granted within NUM_REQ accept opportunities.
  - Response consume and completion into different slots in the same cycle are both honoured.

Test Plan:
- Single request: req0 ADD op1=5, op2=7 accepted at T -> alu_func=1 during T..T+1; rsp_valid[0]=1 after T+1, rsp_result[0]=12, rsp_err[0]=0.
- Contention after reset: req0 SUB(3,5) and req1 SLL(1,4) both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; results 0xFFFFFFFE and 0x10.
- Backpressure: req0 SLT(0xFFFFFFFF,1) with rsp_ready[0]=0 for 5 cycles -> rsp_result[0]=1 held stable; req_ready[0]=0 for a new req0 meanwhile; req1 still served.
- Illegal code: req1 func=12, ops 9,9 -> alu_func=0, rsp_result[1]=0, rsp_err[1]=1. Func=0 -> result 0, err=0.
- Signed vs unsigned: SRA(0x80000000,4) -> 0xF8000000; SRL same -> 0x08000000; SLTU(0xFFFFFFFF,1) -> 0.
- Reset mid-operation: rst_n=0 at the edge after req0 accept -> no rsp_valid appears; after release, the first simultaneous req0/req1 grant goes to req0.
